// File: rtl/tcdm_filter_cfg_if.sv
// tcdm_filter_cfg_if: TCDM request/response bundle between a bus master and the filter config slave
interface tcdm_filter_cfg_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic                  gnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_valid;
    modport master (output req, add, wen, wdata, be, input gnt, r_rdata, r_valid);
    modport slave (input req, add, wen, wdata, be, output gnt, r_rdata, r_valid);
endinterface

// File: rtl/tcdm_filter_cfg_slave.sv
// tcdm_filter_cfg_slave: config/rule registers and first-error capture for the TCDM address filter
module tcdm_filter_cfg_slave #(
    parameter int N_RULES    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tcdm_filter_cfg_if.slave         bus,
    output logic [N_RULES-1:0][31:0] rules_o,
    output logic                     filter_en_o,
    input  logic                     error_i,
    input  logic [ADDR_WIDTH-1:0]    err_add_i,
    output logic                     irq_o
);
    logic [2:0]            ctrl;
    logic                  err, ovf, wr, clr_err, clr_ovf, unused;
    logic [ADDR_WIDTH-1:0] err_addr;
    logic [15:0]           err_cnt, cnt_base;
    logic [5:0]            idx;
    logic [DATA_WIDTH-1:0] rd_mux;
    assign idx         = bus.add[7:2];
    assign unused      = ^{bus.add[ADDR_WIDTH-1:8], bus.add[1:0]};
    assign bus.gnt     = bus.req;
    assign wr          = bus.req & ~bus.wen;
    assign clr_err     = wr && idx == 6'd1 && bus.be[0] && bus.wdata[0];
    assign clr_ovf     = wr && idx == 6'd1 && bus.be[0] && bus.wdata[1];
    assign cnt_base    = clr_err ? 16'd0 : err_cnt;
    assign filter_en_o = ctrl[0];
    assign irq_o       = err & ctrl[1];
    always_comb begin
        rd_mux = idx == 6'd0 ? {29'd0, ctrl} :
                 idx == 6'd1 ? {30'd0, ovf, err} :
                 idx == 6'd2 ? err_addr :
                 idx == 6'd3 ? {16'd0, err_cnt} : 32'hBADE5505;
        for (int i = 0; i < N_RULES; i++)
            if (idx == 6'(8 + i)) rd_mux = rules_o[i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.r_valid <= 1'b0;
            bus.r_rdata <= '0;
            ctrl        <= '0;
            rules_o     <= '0;
            err         <= 1'b0;
            ovf         <= 1'b0;
            err_addr    <= '0;
            err_cnt     <= '0;
        end else begin
            bus.r_valid <= bus.req;
            if (bus.req) bus.r_rdata <= bus.wen ? rd_mux : '0;
            if (wr && idx == 6'd0 && !ctrl[2] && bus.be[0]) ctrl <= bus.wdata[2:0];
            for (int i = 0; i < N_RULES; i++)
                for (int k = 0; k < BE_WIDTH; k++)
                    if (wr && !ctrl[2] && idx == 6'(8 + i) && bus.be[k])
                        rules_o[i][8*k +: 8] <= bus.wdata[8*k +: 8];
            // a new error in the clearing cycle counts as the first error of a fresh window
            err <= (err & ~clr_err) | error_i;
            ovf <= (ovf & ~clr_ovf) | (error_i & err & ~clr_err);
            if (error_i && (!err || clr_err)) err_addr <= err_add_i;
            err_cnt <= (error_i && cnt_base != 16'hFFFF) ? cnt_base + 16'd1 : cnt_base;
        end
    end
endmodule

// File: doc/tcdm_filter_cfg_slave.md
# tcdm_filter_cfg_slave

TCDM responder that owns the configuration and error-reporting registers for the TCDM address filter. It sits on the peripheral TCDM/APB-bridged bus. It drives the filter's rule vector and enable. It captures filter error events (first faulting address, count, overflow) and raises an interrupt.

## Interface
- N_RULES, 8, number of rule registers driven on rules_o; legal range 1..24.
- DATA_WIDTH, 32, TCDM data width; only 32 supported.
- ADDR_WIDTH, 32, TCDM address width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  1  TCDM request.
- add_i  in  ADDR_WIDTH  byte address; only add_i[7:2] decoded.
- wen_i  in  1  1 = read, 0 = write.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables for writes.
- gnt_o  out  1  grant.
- r_rdata_o  out  32  read response data.
- r_valid_o  out  1  response valid, for reads and writes.
- rules_o  out  N_RULES x 32  rule words to the filter: {A[31:30], BASE[29:15], SIZE[14:1], S[0]}.
- filter_en_o  out  1  filter enable (CTRL.EN).
- error_i  in  1  filter error strobe; one event per cycle high.
- err_add_i  in  ADDR_WIDTH  offending address, valid with error_i.
- irq_o  out  1  error interrupt, level.

## Operation
- Register map, byte offsets:
  - 0x00 CTRL, RW: [0] EN, [1] IRQ_EN, [2] LOCK.
  - 0x04 STATUS: [0] ERR, [1] OVF; write-1-to-clear.
  - 0x08 ERR_ADDR, RO.
  - 0x0C ERR_CNT, RO: [15:0] count, upper bits 0.
  - 0x20 + 4*i: RULE[i], RW, for i < N_RULES.
- Unmapped offsets, and RULE slots at i >= N_RULES:
  - reads return 32'hBADE5505;
  - writes are ignored;
  - the response still completes normally.
- Writes apply per byte where be_i[k]=1. CTRL bits [31:3] read 0.
- LOCK:
  - Once CTRL.LOCK=1, all writes to CTRL and RULE[*] are ignored until reset.
  - STATUS W1C still works.
  - The write that sets LOCK also applies its EN/IRQ_EN bytes.
- Error capture, per cycle with error_i=1:
  - If ERR=0: ERR_ADDR <= err_add_i, ERR <= 1.
  - Else: OVF <= 1, and ERR_ADDR is held (first error kept).
  - ERR_CNT increments, saturating at 16'hFFFF.
- STATUS write with wdata[0]=1, be_i[0]=1: clears ERR and ERR_CNT.
- STATUS write with wdata[1]=1: clears OVF.
- Same cycle as error_i, error wins:
  - clearing ERR: result ERR=1, ERR_ADDR=err_add_i, ERR_CNT=1;
  - clearing OVF while ERR was already 1: OVF stays 1.
- irq_o = STATUS.ERR & CTRL.IRQ_EN, driven from registers (no comb path from error_i).
- filter_en_o = CTRL.EN; rules_o = RULE registers, direct register outputs.

## Timing
- Zero-wait-state: gnt_o = req_i, combinational.
- Accepted request at edge T → r_valid_o=1 for exactly one cycle after T.
  - r_rdata_o is valid in that cycle, and registered.
  - r_rdata_o is 0 for writes.
  - Back-to-back requests give back-to-back r_valid_o pulses.
- Read data reflects register state before edge T. Same-cycle error capture is not visible.
- Writes update registers at edge T. rules_o, filter_en_o and irq_o change in the cycle after T.
- r_rdata_o holds its last value when r_valid_o=0.
- Reset values:
  - CTRL=0, all RULE=0 (all rules inactive, S=0);
  - STATUS=0, ERR_ADDR=0, ERR_CNT=0;
  - r_valid_o=0, r_rdata_o=0, irq_o=0, filter_en_o=0.
- Reset asserted mid-transaction: any pending response is dropped (r_valid_o=0 immediately); no response after release.

## Test plan
- Reset, then read 0x00, 0x04, 0x08, 0x0C, 0x20 → gnt same cycle; r_valid one cycle later, each returning 0; read 0x10 → 32'hBADE5505.
- Write RULE[3] = 32'h1234_5679 with be=4'b0101 → rules_o[3]=32'h0034_0079 the next cycle; read back → same value.
- Write CTRL=7 (EN, IRQ_EN, LOCK), then write CTRL=0 and RULE[0]=32'hFFFF_FFFF:
  - filter_en_o stays 1;
  - RULE[0] reads 0.
- Pulse error_i with err_add_i=0x1C01_0000, then 0x1C02_0000:
  - ERR_ADDR=0x1C01_0000, ERR_CNT=2, STATUS=3;
  - irq_o=1 one cycle after the first pulse.
- W1C STATUS=1 in the same cycle as error_i with 0x1A10_0040 → ERR=1, ERR_ADDR=0x1A10_0040, ERR_CNT=1.
- Hold error_i for 70000 cycles → ERR_CNT saturates at 16'hFFFF; then W1C STATUS=3 → STATUS=0, ERR_CNT=0, irq_o=0 the next cycle.
